// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM arbiter.
package ram_arb_pkg;
    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;
    localparam int ARB_AW = 12;
endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: two-way round-robin pick plus the last-grant register.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic upd,
    output gnt_t gnt,
    output gnt_t last
);
    // Under contention the port that did not win last time goes first.
    always_comb gnt = (i_req && d_req) ? (last == GNT_I ? GNT_D : GNT_I) : (d_req ? GNT_D : GNT_I);

    always_ff @(posedge clk or posedge rst)
        if (rst) last <= GNT_I;
        else if (upd) last <= gnt;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered-read RAM between an instruction and a data port.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_stb_i,
    input  logic [AW-1:0] i_adr_i,
    output logic [31:0]   i_dat_o,
    output logic          i_ack_o,
    input  logic          d_stb_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_adr_i,
    input  logic [3:0]    d_sel_i,
    input  logic [31:0]   d_dat_i,
    output logic [31:0]   d_dat_o,
    output logic          d_ack_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [3:0]    ram_be_o,
    output logic [31:0]   ram_dat_o,
    input  logic [31:0]   ram_dat_i,
    output logic [CW-1:0] conflicts_o
);
    state_t state, state_nxt;
    gnt_t   gnt, last;
    logic   take, use_d;

    assign take  = state == IDLE && (i_stb_i || d_stb_i);
    assign use_d = gnt == GNT_D;

    // last already holds the winner while in RESP, so it selects the ack.
    ram_arb_rr u_rr (
        .clk  (clk_i),
        .rst  (rst_i),
        .i_req(i_stb_i),
        .d_req(d_stb_i),
        .upd  (take),
        .gnt  (gnt),
        .last (last)
    );

    always_comb begin
        state_nxt = take ? RESP : IDLE;
        ram_adr_o = use_d ? d_adr_i : i_adr_i;
        ram_we_o  = take && use_d && d_we_i;
        ram_be_o  = (take && use_d) ? d_sel_i : 4'h0;
        ram_dat_o = d_dat_i;
        i_ack_o   = state == RESP && last == GNT_I;
        d_ack_o   = state == RESP && last == GNT_D;
        i_dat_o   = ram_dat_i;
        d_dat_o   = ram_dat_i;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) conflicts_o <= '0;
        else if (state == IDLE && i_stb_i && d_stb_i && conflicts_o != '1) conflicts_o <= conflicts_o + CW'(1);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of the RAM arbiter against a registered-read RAM model.
module tb_ram_arbiter;
    localparam int AW = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_stb = 1'b0, d_stb = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_adr = '0, d_adr = '0;
    logic [3:0]    d_sel = 4'h0;
    logic [31:0]   d_wdat = '0;
    logic [31:0]   i_dat, d_dat, ram_wdat;
    logic [31:0]   ram_rdat = '0;
    logic          i_ack, d_ack, ram_we;
    logic [AW-1:0] ram_adr;
    logic [3:0]    ram_be;
    logic [CW-1:0] conflicts;
    logic [31:0]   mem [0:(1<<AW)-1];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .CW(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_stb_i(i_stb), .i_adr_i(i_adr), .i_dat_o(i_dat), .i_ack_o(i_ack),
        .d_stb_i(d_stb), .d_we_i(d_we), .d_adr_i(d_adr), .d_sel_i(d_sel),
        .d_dat_i(d_wdat), .d_dat_o(d_dat), .d_ack_o(d_ack),
        .ram_we_o(ram_we), .ram_adr_o(ram_adr), .ram_be_o(ram_be),
        .ram_dat_o(ram_wdat), .ram_dat_i(ram_rdat), .conflicts_o(conflicts)
    );

    // Byte-enabled RAM with read-first registered output.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we && ram_be[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
        ram_rdat <= mem[ram_adr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = 32'h0;
        mem[0] = 32'h3c1d8000;
        mem[1] = 32'hAAAA0001;
        mem[2] = 32'hBBBB0002;
        mem[5] = 32'h11223344;
        #12 rst = 1'b0;
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_be", 32'(ram_be), 32'd0);
        check("rst_conf", 32'(conflicts), 32'd0);

        // Instruction read of word 0
        i_stb = 1'b1; i_adr = '0;
        #1;
        check("ird_idle_we", 32'(ram_we), 32'd0);
        check("ird_idle_be", 32'(ram_be), 32'd0);
        check("ird_idle_adr", 32'(ram_adr), 32'd0);
        step();
        check("ird_ack", 32'(i_ack), 32'd1);
        check("ird_dack", 32'(d_ack), 32'd0);
        check("ird_dat", i_dat, 32'h3c1d8000);
        check("ird_resp_we", 32'(ram_we), 32'd0);
        i_stb = 1'b0;
        step();
        check("ird_ack_off", 32'(i_ack), 32'd0);

        // Byte-1 write to word 5, then read it back
        d_stb = 1'b1; d_we = 1'b1; d_adr = 12'd5; d_sel = 4'b0010; d_wdat = 32'h0000AB00;
        #1;
        check("dwr_we", 32'(ram_we), 32'd1);
        check("dwr_be", 32'(ram_be), 32'h2);
        check("dwr_adr", 32'(ram_adr), 32'd5);
        check("dwr_wdat", ram_wdat, 32'h0000AB00);
        step();
        check("dwr_ack", 32'(d_ack), 32'd1);
        check("dwr_resp_we", 32'(ram_we), 32'd0);
        d_stb = 1'b0; d_we = 1'b0;
        step();
        check("dwr_ack_off", 32'(d_ack), 32'd0);
        d_stb = 1'b1;
        step();
        check("drd_ack", 32'(d_ack), 32'd1);
        check("drd_dat", d_dat, 32'h1122AB44);
        d_stb = 1'b0;
        step();

        // Contention from reset: D,I,D,I then saturation at 15
        rst = 1'b1; #2 rst = 1'b0;
        i_stb = 1'b1; i_adr = 12'd1; d_stb = 1'b1; d_adr = 12'd2;
        for (int k = 0; k < 4; k++) begin
            step();
            check("cont_dack", 32'(d_ack), 32'(k % 2 == 0));
            check("cont_iack", 32'(i_ack), 32'(k % 2 == 1));
            check("cont_dat", (k % 2 == 0) ? d_dat : i_dat, (k % 2 == 0) ? 32'hBBBB0002 : 32'hAAAA0001);
            check("cont_conf", 32'(conflicts), 32'(k + 1));
            step();
            check("cont_gap", 32'(i_ack | d_ack), 32'd0);
        end
        for (int k = 0; k < 30; k++) step();
        check("sat_conf", 32'(conflicts), 32'd15);
        for (int k = 0; k < 6; k++) step();
        check("sat_hold", 32'(conflicts), 32'd15);
        i_stb = 1'b0; d_stb = 1'b0;
        step();
        step();
        check("sat_idle", 32'(i_ack | d_ack), 32'd0);

        // Reset during RESP of a data read
        d_stb = 1'b1; d_we = 1'b0; d_adr = 12'd2;
        step();
        check("rr_ack_before", 32'(d_ack), 32'd1);
        rst = 1'b1;
        #1;
        check("rr_ack_killed", 32'(d_ack), 32'd0);
        check("rr_conf", 32'(conflicts), 32'd0);
        check("rr_we", 32'(ram_we), 32'd0);
        #1 rst = 1'b0;
        step();
        check("rr_next_ack", 32'(d_ack), 32'd1);
        check("rr_next_dat", d_dat, 32'hBBBB0002);
        d_stb = 1'b0;
        step();

        // stb dropped during RESP of a write
        d_stb = 1'b1; d_we = 1'b1; d_adr = 12'd7; d_sel = 4'hF; d_wdat = 32'hDEADBEEF;
        step();
        d_stb = 1'b0; d_we = 1'b0;
        #1;
        check("drop_ack", 32'(d_ack), 32'd1);
        step();
        check("drop_ack_once", 32'(d_ack), 32'd0);
        d_stb = 1'b1;
        step();
        check("drop_rd_ack", 32'(d_ack), 32'd1);
        check("drop_rd_dat", d_dat, 32'hDEADBEEF);
        d_stb = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
